spi_burst: RTL and testbench

SPI_BURST -- requirements
Module: spi_burst

---
 rtl/spi_burst.sv | 177 +++++++++++++++++
 tb/tb_spi_burst.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_burst.sv
// Burst engine between a byte host port and a polled SPI controller, with receive FIFO.
// Define SPI_BURST_CRC16_EN to build the CRC-16-CCITT accumulator over received bytes.
module spi_burst #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] bus_addr,
  input  logic [7:0] bus_wrdata,
  output logic [7:0] bus_rddata,
  input  logic       bus_sel,
  input  logic       bus_strobe,
  input  logic       bus_write,
  output logic       m_addr,
  output logic [7:0] m_wrdata,
  input  logic [7:0] m_rddata,
  output logic       m_sel,
  output logic       m_strobe,
  output logic       m_write
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_GAP, S_POLL, S_READ, S_SSEL, S_SGAP
  } state_t;

  state_t          state_q, state_d;
  logic            acc_q;
  logic [8:0]      rem_q, rem_d;
  logic            stall_q, stall_d;
  logic [7:0]      fill_q;
  logic            ssel_q;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      level_q;

  logic host_ev, wr_ev, rd_ev, empty, full, push, pop, busy;

  assign host_ev = bus_sel && bus_strobe && !acc_q;
  assign wr_ev   = host_ev && bus_write;
  assign rd_ev   = host_ev && !bus_write;
  assign empty   = (level_q == 5'd0);
  assign full    = (level_q == 5'(FIFO_DEPTH));
  assign pop     = rd_ev && (bus_addr == 3'd0) && !empty;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    stall_d  = stall_q;
    push     = 1'b0;
    m_sel    = 1'b0;
    m_strobe = 1'b0;
    m_write  = 1'b0;
    m_addr   = 1'b0;
    m_wrdata = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (wr_ev && bus_addr == 3'd0) begin
          rem_d   = (bus_wrdata == 8'h00) ? 9'd256 : {1'b0, bus_wrdata};
          state_d = S_WR;
        end else if (wr_ev && bus_addr == 3'd2) begin
          state_d = S_SSEL;
        end
      end
      S_WR: begin
        m_sel    = 1'b1;
        m_strobe = 1'b1;
        m_write  = 1'b1;
        m_wrdata = fill_q;
        state_d  = S_GAP;
      end
      S_GAP: state_d = S_POLL;
      S_POLL: begin
        m_sel  = 1'b1;
        m_addr = 1'b1;
        if (!m_rddata[1]) state_d = S_READ;
      end
      S_READ: begin
        // stall_q marks cycles after the push spent waiting for FIFO room
        if (!stall_q) begin
          m_sel = 1'b1;
          push  = 1'b1;
          rem_d = rem_q - 9'd1;
          if (rem_q == 9'd1)
            state_d = S_IDLE;
          else if (level_q == 5'(FIFO_DEPTH - 1) && !pop)
            stall_d = 1'b1;
          else
            state_d = S_WR;
        end else if (!full) begin
          stall_d = 1'b0;
          state_d = S_WR;
        end
      end
      S_SSEL: begin
        m_sel    = 1'b1;
        m_strobe = 1'b1;
        m_write  = 1'b1;
        m_addr   = 1'b1;
        m_wrdata = {7'b0, ssel_q};
        state_d  = S_SGAP;
      end
      S_SGAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SPI_BURST_CRC16_EN
  logic [15:0] crc_q;

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++)
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      crc_q <= 16'h0000;
    else if (wr_ev && bus_addr == 3'd3)
      crc_q <= 16'h0000;
    else if (push)
      crc_q <= crc_byte(crc_q, m_rddata);
  end
`endif

  always_comb begin
    bus_rddata = 8'h00;
    case (bus_addr)
      3'd0: bus_rddata = empty ? 8'hFF : mem[rd_ptr_q];
      3'd1: bus_rddata = {busy, full, empty, level_q};
      3'd2: bus_rddata = {7'b0, ssel_q};
`ifdef SPI_BURST_CRC16_EN
      3'd3: bus_rddata = crc_q[7:0];
      3'd4: bus_rddata = crc_q[15:8];
`endif
      default: bus_rddata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= m_rddata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= 1'b0;
      rem_q    <= 9'd0;
      stall_q  <= 1'b0;
      fill_q   <= 8'hFF;
      ssel_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= bus_sel && bus_strobe;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      if (wr_ev && bus_addr == 3'd1) fill_q <= bus_wrdata;
      if (wr_ev && bus_addr == 3'd2 && !busy) ssel_q <= bus_wrdata[0];
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + 5'd1;
        2'b01:   level_q <= level_q - 5'd1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst.sv
// Directed bench for spi_burst with a small polled SPI controller model.
module tb_spi_burst;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] bus_addr = 3'd0;
  logic [7:0] bus_wrdata = 8'h00;
  logic [7:0] bus_rddata;
  logic       bus_sel = 1'b0;
  logic       bus_strobe = 1'b0;
  logic       bus_write = 1'b0;
  logic       m_addr;
  logic [7:0] m_wrdata;
  logic [7:0] m_rddata;
  logic       m_sel;
  logic       m_strobe;
  logic       m_write;

  spi_burst #(.FIFO_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .bus_addr(bus_addr), .bus_wrdata(bus_wrdata), .bus_rddata(bus_rddata),
    .bus_sel(bus_sel), .bus_strobe(bus_strobe), .bus_write(bus_write),
    .m_addr(m_addr), .m_wrdata(m_wrdata), .m_rddata(m_rddata),
    .m_sel(m_sel), .m_strobe(m_strobe), .m_write(m_write)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // controller model: busy for two polls after each data write strobe
  logic [7:0] resp_tab [256];
  int         base = 0;
  int         wr_cnt = 0;
  int         ssel_cnt = 0;
  int         any_strobe = 0;
  int         fill_bad = 0;
  int         strobe_viol = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_fill = 8'hFF;
  logic [7:0] last_ssel = 8'h00;
  logic [7:0] rx_reg = 8'h00;
  logic       prev_strobe = 1'b0;

  assign m_rddata = m_addr ? {6'b0, (busy_cnt != 0), 1'b0} : rx_reg;

  always @(posedge clk) begin
    prev_strobe <= m_strobe;
    if (m_strobe) any_strobe <= any_strobe + 1;
    if (m_strobe && prev_strobe) strobe_viol <= strobe_viol + 1;
    if (m_sel && m_strobe && m_write && !m_addr) begin
      wr_cnt   <= wr_cnt + 1;
      rx_reg   <= resp_tab[8'(wr_cnt - base)];
      busy_cnt <= 2;
      if (m_wrdata !== exp_fill) fill_bad <= fill_bad + 1;
    end else if (m_sel && m_addr && !m_strobe && busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (m_sel && m_strobe && m_write && m_addr) begin
      ssel_cnt  <= ssel_cnt + 1;
      last_ssel <= m_wrdata;
    end
  end

  task automatic host_wr(input logic [2:0] a, input logic [7:0] d);
    bus_addr = a; bus_wrdata = d; bus_write = 1'b1; bus_sel = 1'b1; bus_strobe = 1'b1;
    @(negedge clk);
    bus_strobe = 1'b0; bus_sel = 1'b0; bus_write = 1'b0;
    @(negedge clk);
  endtask

  task automatic host_rd(input logic [2:0] a, output logic [7:0] d);
    bus_addr = a; bus_write = 1'b0; bus_sel = 1'b1; bus_strobe = 1'b1;
    #1 d = bus_rddata;
    @(negedge clk);
    bus_strobe = 1'b0; bus_sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    logic [7:0] st;
    st = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      host_rd(3'd1, st);
      if (!st[7]) break;
    end
    check(tag, st[7], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  logic [7:0] d, st;
  int         reads, got, strobes_at;
  logic       hit;

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_msel", m_sel, 1'b0);
    check("rst_mstrobe", m_strobe, 1'b0);
    check("rst_mwrdata", m_wrdata, 8'h00);
    host_rd(3'd1, d); check("rst_status", d, 8'h20);
    host_rd(3'd0, d); check("rst_empty_rd", d, 8'hFF);
    host_rd(3'd2, d); check("rst_ssel", d, 8'h00);

    // three-byte burst with default fill
    base = wr_cnt;
    resp_tab[0] = 8'h11; resp_tab[1] = 8'h22; resp_tab[2] = 8'h33;
    exp_fill = 8'hFF;
    host_wr(3'd1, 8'hFF);
    host_wr(3'd0, 8'd3);
    wait_idle("b3_idle");
    check("b3_strobes", wr_cnt - base, 3);
    host_rd(3'd1, d); check("b3_status", d, 8'h03);
    host_rd(3'd0, d); check("b3_byte0", d, 8'h11);
    host_rd(3'd0, d); check("b3_byte1", d, 8'h22);
    host_rd(3'd0, d); check("b3_byte2", d, 8'h33);
    host_rd(3'd0, d); check("b3_empty", d, 8'hFF);
    host_rd(3'd1, d); check("b3_status_end", d, 8'h20);

    // writes while busy are ignored
    base = wr_cnt;
    resp_tab[0] = 8'hA1; resp_tab[1] = 8'hA2;
    host_wr(3'd1, 8'hA5);
    exp_fill = 8'hA5;
    host_wr(3'd0, 8'd2);
    host_wr(3'd0, 8'd7);
    host_wr(3'd2, 8'h01);
    wait_idle("busy_idle");
    check("busy_strobes", wr_cnt - base, 2);
    check("busy_ssel_cnt", ssel_cnt, 0);
    host_rd(3'd1, d); check("busy_status", d, 8'h02);
    host_rd(3'd2, d); check("busy_ssel_rd", d, 8'h00);
    host_rd(3'd0, d); check("busy_byte0", d, 8'hA1);
    host_rd(3'd0, d); check("busy_byte1", d, 8'hA2);

    // slave select while idle
    host_wr(3'd2, 8'h01);
    repeat (3) @(negedge clk);
    check("ssel1_cnt", ssel_cnt, 1);
    check("ssel1_data", last_ssel, 8'h01);
    host_rd(3'd2, d); check("ssel1_rd", d, 8'h01);
    host_rd(3'd1, d); check("ssel1_status", d, 8'h20);
    host_wr(3'd2, 8'h00);
    repeat (3) @(negedge clk);
    check("ssel0_cnt", ssel_cnt, 2);
    check("ssel0_data", last_ssel, 8'h00);
    check("ssel_no_wr", wr_cnt - base, 2);

`ifdef SPI_BURST_CRC16_EN
    base = wr_cnt;
    for (int k = 0; k < 9; k++) resp_tab[k] = 8'h31 + 8'(k);
    host_wr(3'd3, 8'h00);
    host_wr(3'd0, 8'd9);
    wait_idle("crc_idle");
    host_rd(3'd3, d); check("crc_lo", d, 8'hC3);
    host_rd(3'd4, d); check("crc_hi", d, 8'h31);
    for (int k = 0; k < 9; k++) begin
      host_rd(3'd0, d); check("crc_byte", d, 8'h31 + 8'(k));
    end
    host_wr(3'd3, 8'h00);
    host_rd(3'd3, d); check("crc_clr", d, 8'h00);
`else
    host_wr(3'd3, 8'h5A);
    host_rd(3'd3, d); check("nocrc_lo", d, 8'h00);
    host_rd(3'd4, d); check("nocrc_hi", d, 8'h00);
`endif
    host_rd(3'd5, d); check("addr5_rd", d, 8'h00);

    // pop coincident with the fifth push at level 4
    base = wr_cnt;
    for (int k = 0; k < 5; k++) resp_tab[k] = 8'h51 + 8'(k);
    host_wr(3'd0, 8'd5);
    reads = 0; hit = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (m_sel && !m_strobe && !m_addr && !m_write) begin
        reads++;
        if (reads == 5) begin
          host_rd(3'd0, d);
          hit = 1'b1;
          break;
        end
      end
    end
    check("pp_hit", hit, 1'b1);
    check("pp_pop", d, 8'h51);
    wait_idle("pp_idle");
    host_rd(3'd1, d); check("pp_level", d, 8'h04);
    for (int k = 1; k < 5; k++) begin
      host_rd(3'd0, d); check("pp_order", d, 8'h51 + 8'(k));
    end

    // 256-byte burst: stall on full, then drain during transfer
    base = wr_cnt;
    for (int k = 0; k < 256; k++) resp_tab[k] = 8'(k) ^ 8'h5A;
    host_wr(3'd0, 8'd0);
    st = 8'h00;
    for (int n = 0; n < 400; n++) begin
      host_rd(3'd1, st);
      if (st[6]) break;
    end
    check("full_status", st, 8'hD0);
    strobes_at = any_strobe;
    repeat (30) @(negedge clk);
    check("full_no_strobe", any_strobe - strobes_at, 0);
    check("full_wr_cnt", wr_cnt - base, 16);
    got = 0;
    for (int n = 0; n < 20000 && got < 256; n++) begin
      host_rd(3'd1, st);
      if (!st[5]) begin
        host_rd(3'd0, d);
        check("long_byte", d, 8'(got) ^ 8'h5A);
        got++;
      end
    end
    check("long_count", got, 256);
    wait_idle("long_idle");
    check("long_strobes", wr_cnt - base, 256);
    host_rd(3'd1, d); check("long_status", d, 8'h20);

    // reset during poll of the second byte
    base = wr_cnt;
    for (int k = 0; k < 4; k++) resp_tab[k] = 8'h71 + 8'(k);
    host_wr(3'd0, 8'd4);
    hit = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wr_cnt - base == 2 && m_sel && m_addr && !m_strobe) begin
        hit = 1'b1;
        break;
      end
    end
    check("rp_found", hit, 1'b1);
    rst_n = 1'b0;
    bus_addr = 3'd1;
    #1;
    check("rp_msel", m_sel, 1'b0);
    check("rp_maddr", m_addr, 1'b0);
    check("rp_status", bus_rddata, 8'h20);
    @(negedge clk);
    rst_n = 1'b1;
    strobes_at = any_strobe;
    @(posedge clk);
    #1 check("rp_first_strobe", m_strobe, 1'b0);
    repeat (10) @(negedge clk);
    check("rp_no_strobe", any_strobe - strobes_at, 0);
    host_rd(3'd1, d); check("rp_status_after", d, 8'h20);

    // fill returns to 0xFF after reset
    base = wr_cnt;
    resp_tab[0] = 8'h99;
    exp_fill = 8'hFF;
    host_wr(3'd0, 8'd1);
    wait_idle("rf_idle");
    check("rf_strobes", wr_cnt - base, 1);
    host_rd(3'd0, d); check("rf_byte", d, 8'h99);

    check("fill_errors", fill_bad, 0);
    check("strobe_back_to_back", strobe_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
